// File: rtl/vmem_seq_if.sv
// Word-wide memory port between the vector sequencer (master) and the memory (slave).
interface vmem_seq_if #(
  parameter int N = 32
);
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/vmem_seq.sv
// Splits one V-bit vector load/store into BEATS word transfers and stalls the pipeline meanwhile.
// Optional per-beat ack timeout with sticky err: define VMEM_SEQ_TIMEOUT_EN.
module vmem_seq #(
  parameter int V   = 128,
  parameter int N   = 32,
  parameter int TMO = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memrd_M,
  input  logic             memwr_M,
  input  logic [N-1:0]     addr_M,
  input  logic [V-1:0]     wdata_M,
  output logic [V-1:0]     rdata_M,
  vmem_seq_if.master       mem,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             stall_W,
  output logic             err
);

  localparam int BEATS = V / N;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (TMO < 1 || TMO > 255 || (V % N) != 0 || BEATS < 1) begin : g_bad_cfg
    $error("vmem_seq: V must be a multiple of N and TMO must fit the 8-bit wait counter");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            wr_q, wr_d;
  logic [V-1:0]    rdata_q, rdata_d;
  logic            stall;

`ifdef VMEM_SEQ_TIMEOUT_EN
  logic [7:0]      wait_q, wait_d;
  logic            err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
`ifdef VMEM_SEQ_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
`ifdef VMEM_SEQ_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
`ifdef VMEM_SEQ_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (memrd_M || memwr_M) begin
          state_d = XFER;
          beat_d  = '0;
          wr_d    = !memrd_M;
`ifdef VMEM_SEQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      XFER: begin
        if (mem.mem_ack) begin
          if (!wr_q) begin
            rdata_d[int'(beat_q)*N +: N] = mem.mem_rdata;
          end
          if (beat_q == BW'(BEATS - 1)) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
`ifdef VMEM_SEQ_TIMEOUT_EN
          wait_d = '0;
        end else if (wait_q == 8'(TMO - 1)) begin
          // Give up on this beat: lanes not yet captured read back as zero.
          err_d   = 1'b1;
          state_d = DONE;
          wait_d  = '0;
          if (!wr_q) begin
            for (int k = 0; k < BEATS; k++) begin
              if (k >= int'(beat_q)) begin
                rdata_d[k*N +: N] = '0;
              end
            end
          end
        end else begin
          wait_d = wait_q + 8'd1;
`endif
        end
      end
      DONE: begin
        // One-cycle release so a still-asserted request cannot retrigger.
        state_d = IDLE;
        beat_d  = '0;
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    stall         = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = memrd_M || memwr_M;
      end
      XFER: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = wr_q;
        mem.mem_addr  = addr_M + (N'(beat_q) << 2);
        mem.mem_wdata = wdata_M[int'(beat_q)*N +: N];
        stall         = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign stall_F = stall;
  assign stall_D = stall;
  assign stall_E = stall;
  assign stall_M = stall;
  assign stall_W = stall;
  assign rdata_M = rdata_q;

`ifdef VMEM_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vmem_seq.sv
// Directed bench for vmem_seq: cycle tables for load/store/wait/back-to-back, hand sequences for reset and timeout.
module tb_vmem_seq;

  logic         clk;
  logic         rst;
  logic         memrd_M;
  logic         memwr_M;
  logic [31:0]  addr_M;
  logic [127:0] wdata_M;
  logic [127:0] rdata_M;
  logic         stall_F, stall_D, stall_E, stall_M, stall_W;
  logic         err;

  vmem_seq_if #(.N(32)) mem_if ();

  vmem_seq #(.V(128), .N(32), .TMO(255)) dut (
    .clk     (clk),
    .rst     (rst),
    .memrd_M (memrd_M),
    .memwr_M (memwr_M),
    .addr_M  (addr_M),
    .wdata_M (wdata_M),
    .rdata_M (rdata_M),
    .mem     (mem_if),
    .stall_F (stall_F),
    .stall_D (stall_D),
    .stall_E (stall_E),
    .stall_M (stall_M),
    .stall_W (stall_W),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic         ack;
    logic [31:0]  rdin;
    logic [31:0]  addr;
    logic         exp_req;
    logic         exp_we;
    logic [31:0]  exp_addr;
    logic [31:0]  exp_wdata;
    logic         exp_stall;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] W   = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] L   = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] C1  = 128'h00000044_00000033_00000022_00000055;
  localparam logic [127:0] C2  = 128'h00000044_00000033_00000066_00000055;
  localparam logic [127:0] C3  = 128'h00000044_00000077_00000066_00000055;
  localparam logic [127:0] CF  = 128'h00000088_00000077_00000066_00000055;
  localparam logic [127:0] D1  = 128'h00000088_00000077_00000066_00000001;
  localparam logic [127:0] D2  = 128'h00000088_00000077_00000002_00000001;
  localparam logic [127:0] D3  = 128'h00000088_00000003_00000002_00000001;
  localparam logic [127:0] DF1 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] E1  = 128'h00000004_00000003_00000002_00000005;
  localparam logic [127:0] E2  = 128'h00000004_00000003_00000006_00000005;
  localparam logic [127:0] E3  = 128'h00000004_00000007_00000006_00000005;
  localparam logic [127:0] DF2 = 128'h00000008_00000007_00000006_00000005;
  localparam logic [127:0] R1  = 128'h00000008_00000007_00000006_00000012;
  localparam logic [127:0] RF  = 128'h000000F4_000000F3_000000F2_000000F1;

  function automatic vec_t mk(input logic rd, input logic wr, input logic ack,
                              input logic [31:0] rdin, input logic [31:0] addr,
                              input logic req, input logic we, input logic [31:0] eaddr,
                              input logic [31:0] ewdata, input logic stall,
                              input logic [127:0] erdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ack = ack; v.rdin = rdin; v.addr = addr;
    v.exp_req = req; v.exp_we = we; v.exp_addr = eaddr; v.exp_wdata = ewdata;
    v.exp_stall = stall; v.exp_rdata = erdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] stalls();
    return {stall_F, stall_D, stall_E, stall_M, stall_W};
  endfunction

  task automatic apply_stimulus(input vec_t v);
    memrd_M          = v.rd;
    memwr_M          = v.wr;
    addr_M           = v.addr;
    mem_if.mem_ack   = v.ack;
    mem_if.mem_rdata = v.rdin;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check($sformatf("row%0d mem_req", idx), mem_if.mem_req, v.exp_req);
    if (v.exp_req) begin
      check($sformatf("row%0d mem_we", idx), mem_if.mem_we, v.exp_we);
      check($sformatf("row%0d mem_addr", idx), mem_if.mem_addr, v.exp_addr);
      if (v.exp_we) check($sformatf("row%0d mem_wdata", idx), mem_if.mem_wdata, v.exp_wdata);
    end
    check($sformatf("row%0d stalls", idx), stalls(), {5{v.exp_stall}});
    check($sformatf("row%0d rdata_M", idx), rdata_M, v.exp_rdata);
    check($sformatf("row%0d err", idx), err, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst              = 1'b0;
    memrd_M          = 1'b0;
    memwr_M          = 1'b0;
    addr_M           = '0;
    wdata_M          = W;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;

    // Load 0x100 with zero-wait acks; acks in IDLE/DONE must be ignored.
    vecs.push_back(mk(1,0,1,32'hDEAD,32'h100, 0,0,0,0, 1, 0));
    vecs.push_back(mk(1,0,1,32'h11,  32'h100, 1,0,32'h100,0, 1, 0));
    vecs.push_back(mk(1,0,1,32'h22,  32'h100, 1,0,32'h104,0, 1, 128'h11));
    vecs.push_back(mk(1,0,1,32'h33,  32'h100, 1,0,32'h108,0, 1, 128'h22_00000011));
    vecs.push_back(mk(1,0,1,32'h44,  32'h100, 1,0,32'h10C,0, 1, 128'h33_00000022_00000011));
    vecs.push_back(mk(0,0,1,32'hBEEF,32'h100, 0,0,0,0, 0, L));
    vecs.push_back(mk(0,0,0,32'h0,   32'h100, 0,0,0,0, 0, L));
    // Store: lanes in order, rdata_M untouched.
    vecs.push_back(mk(0,1,0,32'h0,   32'h100, 0,0,0,0, 1, L));
    vecs.push_back(mk(0,1,1,32'h99,  32'h100, 1,1,32'h100,32'hAAAAAAAA, 1, L));
    vecs.push_back(mk(0,1,1,32'h99,  32'h100, 1,1,32'h104,32'hBBBBBBBB, 1, L));
    vecs.push_back(mk(0,1,1,32'h99,  32'h100, 1,1,32'h108,32'hCCCCCCCC, 1, L));
    vecs.push_back(mk(0,1,1,32'h99,  32'h100, 1,1,32'h10C,32'hDDDDDDDD, 1, L));
    vecs.push_back(mk(0,0,0,32'h0,   32'h100, 0,0,0,0, 0, L));
    // Load with three wait cycles on beat 2.
    vecs.push_back(mk(1,0,0,32'h0,   32'h100, 0,0,0,0, 1, L));
    vecs.push_back(mk(1,0,1,32'h55,  32'h100, 1,0,32'h100,0, 1, L));
    vecs.push_back(mk(1,0,1,32'h66,  32'h100, 1,0,32'h104,0, 1, C1));
    vecs.push_back(mk(1,0,0,32'hBAD, 32'h100, 1,0,32'h108,0, 1, C2));
    vecs.push_back(mk(1,0,0,32'hBAD, 32'h100, 1,0,32'h108,0, 1, C2));
    vecs.push_back(mk(1,0,0,32'hBAD, 32'h100, 1,0,32'h108,0, 1, C2));
    vecs.push_back(mk(1,0,1,32'h77,  32'h100, 1,0,32'h108,0, 1, C2));
    vecs.push_back(mk(1,0,1,32'h88,  32'h100, 1,0,32'h10C,0, 1, C3));
    vecs.push_back(mk(0,0,0,32'h0,   32'h100, 0,0,0,0, 0, CF));
    // memrd_M held through DONE: exactly four beats, restart only from IDLE.
    vecs.push_back(mk(1,0,0,32'h0,   32'h300, 0,0,0,0, 1, CF));
    vecs.push_back(mk(1,0,1,32'h1,   32'h300, 1,0,32'h300,0, 1, CF));
    vecs.push_back(mk(1,0,1,32'h2,   32'h300, 1,0,32'h304,0, 1, D1));
    vecs.push_back(mk(1,0,1,32'h3,   32'h300, 1,0,32'h308,0, 1, D2));
    vecs.push_back(mk(1,0,1,32'h4,   32'h300, 1,0,32'h30C,0, 1, D3));
    vecs.push_back(mk(1,0,1,32'hEEEE,32'h300, 0,0,0,0, 0, DF1));
    vecs.push_back(mk(1,0,1,32'h5,   32'h300, 0,0,0,0, 1, DF1));
    vecs.push_back(mk(0,0,1,32'h5,   32'h300, 1,0,32'h300,0, 1, DF1));
    vecs.push_back(mk(0,0,1,32'h6,   32'h300, 1,0,32'h304,0, 1, E1));
    vecs.push_back(mk(0,0,1,32'h7,   32'h300, 1,0,32'h308,0, 1, E2));
    vecs.push_back(mk(0,0,1,32'h8,   32'h300, 1,0,32'h30C,0, 1, E3));
    vecs.push_back(mk(0,0,0,32'h0,   32'h300, 0,0,0,0, 0, DF2));

    #1;
    check("reset mem_req", mem_if.mem_req, 1'b0);
    check("reset rdata_M", rdata_M, 128'h0);
    check("reset err", err, 1'b0);
    check("reset stalls", stalls(), 5'b0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    check("idle mem_req", mem_if.mem_req, 1'b0);
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output(vecs[i], i);
      next_cycle();
    end

    // Reset during beat 1 abandons the transfer; next request restarts at beat 0.
    memrd_M = 1'b1; addr_M = 32'h400; mem_if.mem_ack = 1'b0;
    next_cycle();
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h12;
    next_cycle();
    mem_if.mem_ack = 1'b0;
    #1;
    check("rstmid beat1 addr", mem_if.mem_addr, 32'h404);
    check("rstmid beat1 rdata", rdata_M, R1);
    rst = 1'b0;
    #1;
    check("rstmid mem_req", mem_if.mem_req, 1'b0);
    check("rstmid rdata_M", rdata_M, 128'h0);
    memrd_M = 1'b0;
    next_cycle();
    rst = 1'b1;
    #1;
    check("rstmid idle req", mem_if.mem_req, 1'b0);
    check("rstmid idle stalls", stalls(), 5'b0);
    memrd_M = 1'b1;
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      mem_if.mem_ack = 1'b1;
      mem_if.mem_rdata = 32'hF1 + 32'(b);
      #1;
      check($sformatf("restart beat%0d req", b), mem_if.mem_req, 1'b1);
      check($sformatf("restart beat%0d addr", b), mem_if.mem_addr, 32'h400 + 32'(4*b));
      next_cycle();
    end
    memrd_M = 1'b0; mem_if.mem_ack = 1'b0;
    #1;
    check("restart done stalls", stalls(), 5'b0);
    check("restart rdata_M", rdata_M, RF);
    next_cycle();

    // Ack never arrives on beat 0.
    memrd_M = 1'b1; addr_M = 32'h500; mem_if.mem_ack = 1'b0;
    next_cycle();
`ifdef VMEM_SEQ_TIMEOUT_EN
    for (int c = 1; c < 255; c++) next_cycle();
    #1;
    check("tmo last wait req", mem_if.mem_req, 1'b1);
    check("tmo last wait err", err, 1'b0);
    check("tmo last wait rdata", rdata_M, RF);
    next_cycle();
    memrd_M = 1'b0;
    #1;
    check("tmo err", err, 1'b1);
    check("tmo mem_req", mem_if.mem_req, 1'b0);
    check("tmo stalls", stalls(), 5'b0);
    check("tmo rdata_M", rdata_M, 128'h0);
    for (int c = 0; c < 3; c++) next_cycle();
    #1;
    check("tmo err sticky", err, 1'b1);
    rst = 1'b0;
    #1;
    check("tmo err cleared", err, 1'b0);
    next_cycle();
    rst = 1'b1;
`else
    for (int c = 0; c < 300; c++) next_cycle();
    #1;
    check("nowait req", mem_if.mem_req, 1'b1);
    check("nowait addr", mem_if.mem_addr, 32'h500);
    check("nowait stalls", stalls(), 5'b11111);
    check("nowait err", err, 1'b0);
    check("nowait rdata", rdata_M, RF);
    for (int b = 0; b < 4; b++) begin
      mem_if.mem_ack = 1'b1;
      mem_if.mem_rdata = 32'h61 + 32'(b);
      next_cycle();
    end
    memrd_M = 1'b0; mem_if.mem_ack = 1'b0;
    #1;
    check("nowait final rdata", rdata_M, 128'h00000064_00000063_00000062_00000061);
    check("nowait final err", err, 1'b0);
    next_cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmem_seq.md
VMEM_SEQ -- requirements
Module: vmem_seq

Interface
REQ-001 The module SHALL have parameter V, default 128, giving the vector data width in bits.
REQ-002 The module SHALL have parameter N, default 32, giving the memory word width and address width; BEATS = V/N (default 4).
REQ-003 The module SHALL have parameter TMO, default 255, giving the timeout limit in cycles per beat (used only under REQ-027).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 memrd_M  in  1  M-stage vector load request.
REQ-007 memwr_M  in  1  M-stage vector store request.
REQ-008 addr_M  in  N  byte base address of the vector access.
REQ-009 wdata_M  in  V  store data; lane k = bits [N*k+N-1 : N*k].
REQ-010 rdata_M  out  V  assembled load data, feeding the memory-writeback register readdata input.
REQ-011 mem_req, mem_we  out  1  word-port request, write enable.
REQ-012 mem_addr, mem_wdata  out  N  word-port address, write data.
REQ-013 mem_rdata  in  N; mem_ack  in  1  word-port read data, beat acknowledge.
REQ-014 stall_F, stall_D, stall_E, stall_M, stall_W  out  1  pipeline-stage stalls, all driven identically.
REQ-015 err  out  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have three states: IDLE, XFER, DONE.
REQ-017 IDLE: memrd_M or memwr_M high -> XFER next cycle, beat counter = 0, op latched (read if memrd_M is high, otherwise write; both high = read).
REQ-018 XFER: mem_req = 1; mem_we = latched write; mem_addr = addr_M + (beat << 2); mem_wdata = wdata_M lane[beat].
REQ-019 XFER, mem_ack high: on a read, capture mem_rdata into rdata_M lane[beat]; if beat = BEATS-1 -> DONE, else beat + 1.
REQ-020 mem_ack SHALL be ignored when mem_req is low; outputs SHALL remain stable while awaiting ack.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE, ignoring memrd_M/memwr_M in that cycle so one instruction yields one transfer.
REQ-022 All stalls SHALL be combinational: high in IDLE when memrd_M|memwr_M, high in XFER, low in DONE.
REQ-023 With zero-wait ack the stall SHALL last BEATS+1 cycles; the instruction leaves M on the DONE cycle edge.
REQ-024 rdata_M SHALL hold its value outside read beats; lanes not captured retain prior content.
REQ-025 A write SHALL leave rdata_M unchanged.

Reset
REQ-026 rst low SHALL immediately force: state IDLE; beat 0; rdata_M 0; mem_req, mem_we 0; err 0; timeout counter 0. Reset mid-XFER SHALL abandon the transfer with no further beats.

Configuration
REQ-027 Macro VMEM_SEQ_TIMEOUT_EN defined: an 8-bit per-beat wait counter SHALL run in XFER and clear on ack. When the counter reaches TMO without ack: err is set (sticky until reset), uncaptured read lanes are loaded with 0, and the FSM goes to DONE.
REQ-028 Macro VMEM_SEQ_TIMEOUT_EN undefined: XFER SHALL wait indefinitely, err SHALL be tied 0, and no counter SHALL exist.

Verification
REQ-029 Load, addr_M=0x100, ack every cycle, mem_rdata 0x11,0x22,0x33,0x44 -> mem_addr 0x100/104/108/10C; rdata_M=0x00000044_00000033_00000022_00000011; stalls high 5 cycles.
REQ-030 Store, wdata_M=0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> mem_we=1, mem_wdata AAAAAAAA..DDDDDDDD in order; rdata_M unchanged.
REQ-031 Load with 3 ack-wait cycles on beat 2 -> mem_addr holds 0x108 for 4 cycles; stalls high 8 cycles total.
REQ-032 memrd_M held high through DONE -> exactly 4 beats, then a second transfer starts only after IDLE.
REQ-033 rst low during beat 1 -> mem_req 0 same cycle, rdata_M 0, FSM in IDLE; next request restarts at beat 0.
REQ-034 VMEM_SEQ_TIMEOUT_EN defined, no ack for 255 cycles on beat 0 -> err=1, rdata_M=0, DONE, stalls released; err held until reset.
